decode_issue: RTL
=================

DECODE_ISSUE -- requirements
Module: decode_issue

Interface
REQ-001 Parameters SHALL be: DAT_WIDTH 32 (data/address width); CTRL_W 8 (opaque control bundle width); LOAD_STALL 1 (bubbles per load-use hazard, legal 1..3).
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 d_valid_i / d_ready_o  in/out  1/1  decode-side handshake; a transfer occurs when both are high.
REQ-005 ins_d  in  32  instruction; rs1=[19:15], rs2=[24:20], rd=[11:7].
REQ-006 pc_d, pc4_d, rdata1_d, rdata2_d, imm_d  in  DAT_WIDTH each  decode payload and register-file read data.
REQ-007 ctrl_d  in  CTRL_W  control bundle; mem_read_d, reg_write_d  in  1 each  load and writeback flags.
REQ-008 reg_write_w, rd_w, result_w  in  1/5/DAT_WIDTH  writeback port used for forwarding.
REQ-009 flush_i  in  1  branch-taken flush from execute.
REQ-010 e_valid_o / e_ready_i  out/in  1/1  execute-side handshake.
REQ-011 ctrl_e, mem_read_e, reg_write_e, rdata1_e, rdata2_e, imm_e, pc_e, pc4_e, rs1_e, rs2_e, rd_e  out  widths matching their D-side sources (rs/rd 5 bits)  registered execute payload.

Function
REQ-012 The E register SHALL advance when (!e_valid_o || e_ready_i); otherwise every E output SHALL hold its value.
REQ-013 d_ready_o SHALL equal advance && !hazard && (stall_cnt == 0); it SHALL be combinational and independent of d_valid_i.
REQ-014 hazard SHALL be e_valid_o && mem_read_e && rd_e != 0 && (rd_e == ins_d rs1 || rd_e == ins_d rs2) && d_valid_i.
REQ-015 On an advance with a transfer, E SHALL capture all D payload plus forwarded operands, and e_valid_o SHALL become 1.
REQ-016 On an advance without a transfer, a bubble SHALL be inserted: e_valid_o, ctrl_e, mem_read_e and reg_write_e become 0; data fields hold.
REQ-017 Forwarding: rdata1_e SHALL take result_w when reg_write_w && rd_w != 0 && rd_w == rs1; otherwise rdata1_d. rdata2_e SHALL follow the same rule with rs2.
REQ-018 The stall FSM SHALL have states IDLE and STALL, with a counter stall_cnt of width clog2(LOAD_STALL+1).
REQ-019 IDLE -> STALL SHALL occur when hazard is high on an advance, loading stall_cnt with LOAD_STALL-1; if LOAD_STALL == 1, the FSM SHALL remain in IDLE after the single bubble.
REQ-020 In STALL, each advance SHALL insert a bubble and decrement stall_cnt; at 0 the FSM SHALL return to IDLE. A non-advance cycle SHALL freeze the counter.
REQ-021 flush_i SHALL have top priority: on the next edge, e_valid_o and the control outputs become 0, the FSM returns to IDLE, stall_cnt becomes 0, and d_ready_o is ignored that cycle (no transfer is consumed), regardless of e_ready_i.
REQ-022 A register with rd == 0 SHALL never cause a hazard or a forward.

Reset
REQ-023 While rst_n is low at a rising edge, every E output and the performance counters SHALL become 0, the FSM SHALL enter IDLE, and stall_cnt SHALL become 0.
REQ-024 d_ready_o SHALL be 1 in the first cycle after reset if d_valid_i raises no hazard.
REQ-025 Reset SHALL win over flush_i and over any handshake in the same cycle.

Configuration
REQ-026 Macro DECODE_ISSUE_PERF_CNT_EN defined: outputs bubble_cnt_o and flush_cnt_o (32-bit each) SHALL be present.
REQ-027 bubble_cnt_o SHALL count bubbles caused by a hazard or STALL; flush_cnt_o SHALL count cycles with flush_i high. Both SHALL saturate at 0xFFFFFFFF.
REQ-028 Macro undefined: the counter ports and logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-029 Back-to-back stream, e_ready_i = 1, five independent instructions -> one issued per cycle, e_valid_o = 1 from cycle 1.
REQ-030 lw x5 followed by add x6,x5,x1, LOAD_STALL = 2 -> d_ready_o low for 2 cycles, 2 bubbles with reg_write_e = 0, then add issues.
REQ-031 reg_write_w = 1, rd_w = 3, result_w = 0xDEADBEEF, D instruction rs2 = 3 -> rdata2_e = 0xDEADBEEF; repeating with rd_w = 0 -> rdata2_e = rdata2_d.
REQ-032 e_ready_i held low 3 cycles with e_valid_o = 1 -> all E outputs stable and d_ready_o = 0; resumes on release.
REQ-033 flush_i asserted during STALL with stall_cnt = 1 -> next cycle e_valid_o = 0, FSM in IDLE, and a new instruction is accepted the following cycle.
REQ-034 rst_n low mid-stream for 1 edge -> all outputs 0; with DECODE_ISSUE_PERF_CNT_EN defined, both counters read 0.

Source files
------------

// File: rtl/decode_issue.sv
// decode_issue: decode-to-execute issue register with load-use stall FSM, writeback forwarding and flush.
// Optional bubble/flush performance counters are built when DECODE_ISSUE_PERF_CNT_EN is defined.
module decode_issue #(
    parameter int DAT_WIDTH  = 32,
    parameter int CTRL_W     = 8,
    parameter int LOAD_STALL = 1,
    localparam int CNT_W     = $clog2(LOAD_STALL + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    // Both handshakes: a beat moves only on a rising edge where valid && ready; valid never waits on ready.
    input  logic                 d_valid_i,
    output logic                 d_ready_o,
    input  logic [31:0]          ins_d,
    input  logic [DAT_WIDTH-1:0] pc_d,
    input  logic [DAT_WIDTH-1:0] pc4_d,
    input  logic [DAT_WIDTH-1:0] rdata1_d,
    input  logic [DAT_WIDTH-1:0] rdata2_d,
    input  logic [DAT_WIDTH-1:0] imm_d,
    input  logic [CTRL_W-1:0]    ctrl_d,
    input  logic                 mem_read_d,
    input  logic                 reg_write_d,
    input  logic                 reg_write_w,
    input  logic [4:0]           rd_w,
    input  logic [DAT_WIDTH-1:0] result_w,
    input  logic                 flush_i,
    output logic                 e_valid_o,
    input  logic                 e_ready_i,
    output logic [CTRL_W-1:0]    ctrl_e,
    output logic                 mem_read_e,
    output logic                 reg_write_e,
    output logic [DAT_WIDTH-1:0] rdata1_e,
    output logic [DAT_WIDTH-1:0] rdata2_e,
    output logic [DAT_WIDTH-1:0] imm_e,
    output logic [DAT_WIDTH-1:0] pc_e,
    output logic [DAT_WIDTH-1:0] pc4_e,
    output logic [4:0]           rs1_e,
    output logic [4:0]           rs2_e,
    output logic [4:0]           rd_e,
`ifdef DECODE_ISSUE_PERF_CNT_EN
    output logic [31:0]          bubble_cnt_o,
    output logic [31:0]          flush_cnt_o,
`endif
    output logic                 stall_state,
    output logic [CNT_W-1:0]     stall_cnt
);

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_STALL = 1'b1;

    logic [4:0]           rs1_d;
    logic [4:0]           rs2_d;
    logic [4:0]           rd_d;
    logic                 advance;
    logic                 hazard;
    logic                 transfer;
    logic [DAT_WIDTH-1:0] fwd1;
    logic [DAT_WIDTH-1:0] fwd2;
    logic                 state_nxt;
    logic [CNT_W-1:0]     cnt_nxt;
    logic                 unused_ins;

    assign rs1_d      = ins_d[19:15];
    assign rs2_d      = ins_d[24:20];
    assign rd_d       = ins_d[11:7];
    assign unused_ins = ^{ins_d[31:25], ins_d[14:12], ins_d[6:0]};

    assign advance = !e_valid_o || e_ready_i;
    assign hazard  = e_valid_o && mem_read_e && (rd_e != 5'd0) &&
                     ((rd_e == rs1_d) || (rd_e == rs2_d)) && d_valid_i;
    assign d_ready_o = advance && !hazard && (stall_cnt == '0);
    // A flush discards whatever decode offers in the same cycle.
    assign transfer  = d_valid_i && d_ready_o && !flush_i;

    assign fwd1 = (reg_write_w && (rd_w != 5'd0) && (rd_w == rs1_d)) ? result_w : rdata1_d;
    assign fwd2 = (reg_write_w && (rd_w != 5'd0) && (rd_w == rs2_d)) ? result_w : rdata2_d;

    always_comb begin
        state_nxt = stall_state;
        cnt_nxt   = stall_cnt;
        if (flush_i) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
        end else if (advance) begin
            if (stall_state == ST_STALL) begin
                cnt_nxt = stall_cnt - CNT_W'(1);
                if (stall_cnt == CNT_W'(1)) begin
                    state_nxt = ST_IDLE;
                end
            end else if (hazard && (LOAD_STALL > 1)) begin
                // The hazard cycle itself is the first bubble; the counter covers the rest.
                state_nxt = ST_STALL;
                cnt_nxt   = CNT_W'(LOAD_STALL - 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_state <= ST_IDLE;
            stall_cnt   <= '0;
        end else begin
            stall_state <= state_nxt;
            stall_cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            e_valid_o   <= 1'b0;
            ctrl_e      <= '0;
            mem_read_e  <= 1'b0;
            reg_write_e <= 1'b0;
            rdata1_e    <= '0;
            rdata2_e    <= '0;
            imm_e       <= '0;
            pc_e        <= '0;
            pc4_e       <= '0;
            rs1_e       <= '0;
            rs2_e       <= '0;
            rd_e        <= '0;
        end else if (flush_i) begin
            e_valid_o   <= 1'b0;
            ctrl_e      <= '0;
            mem_read_e  <= 1'b0;
            reg_write_e <= 1'b0;
        end else if (advance) begin
            if (transfer) begin
                e_valid_o   <= 1'b1;
                ctrl_e      <= ctrl_d;
                mem_read_e  <= mem_read_d;
                reg_write_e <= reg_write_d;
                rdata1_e    <= fwd1;
                rdata2_e    <= fwd2;
                imm_e       <= imm_d;
                pc_e        <= pc_d;
                pc4_e       <= pc4_d;
                rs1_e       <= rs1_d;
                rs2_e       <= rs2_d;
                rd_e        <= rd_d;
            end else begin
                // Bubble: kill control only, data fields keep their last values.
                e_valid_o   <= 1'b0;
                ctrl_e      <= '0;
                mem_read_e  <= 1'b0;
                reg_write_e <= 1'b0;
            end
        end
    end

`ifdef DECODE_ISSUE_PERF_CNT_EN
    logic stall_bubble;
    assign stall_bubble = advance && !flush_i && (hazard || (stall_state == ST_STALL));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bubble_cnt_o <= '0;
            flush_cnt_o  <= '0;
        end else begin
            if (stall_bubble && (bubble_cnt_o != 32'hFFFF_FFFF)) begin
                bubble_cnt_o <= bubble_cnt_o + 32'd1;
            end
            if (flush_i && (flush_cnt_o != 32'hFFFF_FFFF)) begin
                flush_cnt_o <= flush_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule
